// File: rtl/demux_1to16_seq_pkg.sv
// ============================================================================
// Module   : mux_demux_defs (package)
// Brief    : Shared lane/select widths and FSM state encoding for the demux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_demux_defs;

    localparam int LANES = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/demux_1to16_seq_decoder.sv
// ============================================================================
// Module   : decoder_4to16
// Brief    : 4-bit select to one-hot lane vector, gated by an enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_4to16
    import mux_demux_defs::*;
(
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [LANES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux_1to16_seq.sv
// ============================================================================
// Module   : demux_1to16_seq
// Brief    : Registered 1-to-16 demux with direct writes and counter-driven
//            serial capture (deserializer for a counter-driven 16:1 mux).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_1to16_seq #(
    parameter int LANES     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [3:0]       s,
    input  logic             d,
    input  logic             start,
    input  logic             din_valid,
    output logic [LANES-1:0] z,
    output logic [LANES-1:0] strobe,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import mux_demux_defs::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [LANES-1:0] r_z;
    logic [LANES-1:0] r_strobe;
    logic             w_dec_en;
    logic [3:0]       w_dec_sel;
    logic [3:0]       w_seq_lane;
    logic [LANES-1:0] w_onehot;

    // For a 4-bit count, 15-cnt is simply the bitwise inverse.
    assign w_seq_lane = LSB_FIRST ? r_cnt : ~r_cnt;

    decoder_4to16 u_dec (
        .en     (w_dec_en),
        .sel    (w_dec_sel),
        .onehot (w_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_dec_en    = 1'b0;
        w_dec_sel   = s;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_nxt   = 4'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CAPT;
                    w_err_nxt   = wr_en;
                end else if (wr_en) begin
                    w_dec_en = 1'b1;
                end
            end
            CAPT: begin
                w_err_nxt = wr_en | start;
                if (din_valid) begin
                    w_dec_en  = 1'b1;
                    w_dec_sel = w_seq_lane;
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_state_nxt = FIN;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            FIN: begin
                w_err_nxt   = wr_en | start;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_z      <= '0;
            r_strobe <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_z      <= (r_z & ~w_onehot) | ({LANES{d}} & w_onehot);
            r_strobe <= w_onehot;
        end
    end

    assign z      = r_z;
    assign strobe = r_strobe;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_demux_1to16_seq.sv
// ============================================================================
// Module   : tb_demux_1to16_seq
// Brief    : Directed self-checking bench; a second instance runs MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_1to16_seq;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic [3:0]  s;
    logic        d;
    logic        start;
    logic        din_valid;
    logic [15:0] z, strobe, z_m, strobe_m;
    logic        busy, done, err, busy_m, done_m, err_m;

    int total = 0;
    int bad   = 0;

    demux_1to16_seq #(.LANES(16), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .s(s), .d(d),
        .start(start), .din_valid(din_valid), .z(z), .strobe(strobe),
        .busy(busy), .done(done), .err(err)
    );

    demux_1to16_seq #(.LANES(16), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .s(s), .d(d),
        .start(start), .din_valid(din_valid), .z(z_m), .strobe(strobe_m),
        .busy(busy_m), .done(done_m), .err(err_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    // One full serial capture with optional stalls and conflicting requests.
    task automatic capture(input logic [15:0] word, input bit stall,
                           input bit cflt_capt, input bit cflt_start);
        int          busy_cyc;
        int          done_cyc;
        logic [15:0] prev;
        busy_cyc = 0;
        done_cyc = 0;
        prev     = z;
        start    = 1'b1;
        if (cflt_start) begin
            wr_en = 1'b1; s = 4'd9; d = 1'b1;
        end
        tick();
        start = 1'b0; wr_en = 1'b0; d = 1'b0;
        chk("start_busy", busy, 1);
        if (cflt_start) begin
            chk("start_err", err, 1);
            chk("start_no_write", z, prev);
            chk("start_strobe", strobe, 0);
        end else begin
            chk("start_noerr", err, 0);
        end
        if (busy && !done) busy_cyc++;
        for (int k = 0; k < 16; k++) begin
            if (stall && k > 0) begin
                din_valid = 1'b0; d = ~word[k];
                tick();
                if (busy && !done) busy_cyc++;
                if (done) done_cyc++;
            end
            din_valid = 1'b1; d = word[k];
            if (cflt_capt && k == 5) begin
                wr_en = 1'b1; s = 4'd2;
            end
            tick();
            wr_en = 1'b0;
            if (busy && !done) busy_cyc++;
            if (done) done_cyc++;
            if (cflt_capt && k == 5) begin
                chk("capt_err", err, 1);
                chk("capt_z2", z[2], word[2]);
            end
            if (k == 0) begin
                chk("first_strobe", strobe, 16'h0001);
                chk("first_strobe_msb", strobe_m, 16'h8000);
            end
            if (k < 15 && done) chk("early_done", done, 0);
        end
        chk("done", done, 1);
        chk("z_final", z, word);
        chk("z_final_msb", z_m, rev16(word));
        // din_valid during the FIN cycle must be ignored silently.
        din_valid = 1'b1; d = ~word[15];
        tick();
        din_valid = 1'b0;
        if (busy && !done) busy_cyc++;
        if (done) done_cyc++;
        chk("fin_noerr", err, 0);
        chk("fin_z_hold", z, word);
        tick();
        if (done) done_cyc++;
        chk("busy_cycles", busy_cyc, stall ? 31 : 16);
        chk("done_count", done_cyc, 1);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; s = 4'd0; d = 1'b0;
        start = 1'b0; din_valid = 1'b0;
        tick(); tick();
        chk("rst_z", z, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_flags", {busy, done, err}, 0);
        reset_n = 1'b1;
        tick();

        // Direct writes
        wr_en = 1'b1; s = 4'd5; d = 1'b1;
        tick();
        wr_en = 1'b0; d = 1'b0;
        chk("dir_z", z, 16'h0020);
        chk("dir_strobe", strobe, 16'h0020);
        chk("dir_err", err, 0);
        tick();
        chk("dir_strobe_clr", strobe, 0);
        chk("dir_z_hold", z, 16'h0020);
        wr_en = 1'b1; s = 4'd5; d = 1'b0;
        tick();
        wr_en = 1'b0;
        chk("dir_clear", z, 16'h0000);
        tick();

        // Serial captures
        capture(16'hA5C3, 1'b0, 1'b0, 1'b0);
        capture(16'hA5C3, 1'b1, 1'b0, 1'b0);
        capture(16'h3C5A, 1'b0, 1'b1, 1'b0);
        capture(16'h1234, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a capture
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            din_valid = 1'b1; d = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrst_z", z, 0);
        chk("midrst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        capture(16'hFFFF, 1'b0, 1'b0, 1'b0);

        // Single leading one: MSB-first instance lands it in lane 15
        capture(16'h0001, 1'b0, 1'b0, 1'b0);
        chk("msb_first_z", z_m, 16'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
